// File: rtl/seg_display_scheduler.sv
// Drives a 4-digit multiplexed 7-segment display, sharing it between the live score
// and a handshaked transient message; source switches happen only at frame boundaries.
module seg_display_scheduler #(
    parameter int DIV         = 16,
    parameter int BLANK       = 2,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] score_pat,
    input  logic        msg_req,
    input  logic [31:0] msg_pat,
    output logic        msg_ack,
    output logic        msg_busy,
    output logic [3:0]  digi_an,
    output logic [7:0]  digi_seg
);

    localparam int              SW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SW-1:0]   SLOT_MAX = SW'(DIV - 1);
    localparam logic [7:0]      HOLD_C   = 8'(HOLD_FRAMES);

    typedef enum logic {
        SHOW_SCORE = 1'b0,
        SHOW_MSG   = 1'b1
    } state_t;

    logic [SW-1:0]   slot_q,  slot_d;
    logic [1:0]      digit_q, digit_d;
    state_t          state_q, state_d;
    logic [7:0]      hold_q,  hold_d;
    logic [3:0][7:0] score_buf_q, score_buf_d;
    logic [3:0][7:0] msg_buf_q,   msg_buf_d;
    logic [3:0]      an_q,    an_d;
    logic [7:0]      seg_q,   seg_d;
    logic            ack_q,   ack_d;
    logic            busy_q,  busy_d;

    logic            slot_wrap;
    logic            frame_end;
    logic            accept;
    logic            in_blank;
    logic [3:0][7:0] act_buf;

    // A zero-length blank window must not produce a constant unsigned compare.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [SW-1:0] BLANK_C = SW'(BLANK);
            assign in_blank = (slot_q < BLANK_C);
        end
    endgenerate

    assign slot_wrap = (slot_q == SLOT_MAX);
    assign frame_end = slot_wrap && (digit_q == 2'd3);
    assign accept    = msg_req && !ack_q;
    assign act_buf   = (state_q == SHOW_MSG) ? msg_buf_q : score_buf_q;

    always_comb begin
        slot_d  = slot_wrap ? '0 : slot_q + SW'(1);
        digit_d = slot_wrap ? digit_q + 2'd1 : digit_q;
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        msg_buf_d   = msg_buf_q;
        ack_d       = 1'b0;
        score_buf_d = frame_end ? score_pat : score_buf_q;

        if (frame_end) begin
            case (state_q)
                SHOW_SCORE: begin
                    if (accept) begin
                        msg_buf_d = msg_pat;
                        hold_d    = HOLD_C;
                        ack_d     = 1'b1;
                        state_d   = SHOW_MSG;
                    end
                end
                SHOW_MSG: begin
                    // A newer request supersedes the current message and restarts its hold.
                    if (accept) begin
                        msg_buf_d = msg_pat;
                        hold_d    = HOLD_C;
                        ack_d     = 1'b1;
                    end else if (hold_q <= 8'd1) begin
                        hold_d  = 8'd0;
                        state_d = SHOW_SCORE;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: state_d = SHOW_SCORE;
            endcase
        end

        busy_d = (state_d == SHOW_MSG);
    end

    // Digit 0 is the leftmost digit and lives in the top byte.
    always_comb begin
        an_d  = 4'hF;
        seg_d = 8'hFF;
        if (!in_blank) begin
            an_d  = ~(4'b1000 >> digit_q);
            seg_d = act_buf[2'd3 - digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            digit_q     <= 2'd0;
            state_q     <= SHOW_SCORE;
            hold_q      <= 8'd0;
            score_buf_q <= 32'hFFFF_FFFF;
            msg_buf_q   <= 32'hFFFF_FFFF;
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            digit_q     <= digit_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            score_buf_q <= score_buf_d;
            msg_buf_q   <= msg_buf_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign digi_an  = an_q;
    assign digi_seg = seg_q;
    assign msg_ack  = ack_q;
    assign msg_busy = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench: stimulus pushes the hand-derived display word for every clock edge,
// a negedge monitor pops and compares it against both scheduler instances.
module tb_seg_display_scheduler;

    localparam int DIV  = 4;
    localparam int BLK  = 1;
    localparam int FR   = 4 * DIV;
    localparam int DIV2 = 2;
    localparam int FR2  = 4 * DIV2;

    localparam logic [31:0] BLANKP = 32'hFFFF_FFFF;
    localparam logic [31:0] S      = 32'hC0F9_A4B0;
    localparam logic [31:0] M      = 32'h8E88_C7C7;
    localparam logic [31:0] Z      = 32'h0000_0000;
    localparam logic [31:0] N      = 32'h9282_9982;
    localparam logic [31:0] M2     = 32'hC7C7_C7C7;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       ack;
        logic       busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] score_pat = S;
    logic        msg_req = 1'b0;
    logic [31:0] msg_pat = 32'h0;
    logic        msg_req2 = 1'b0;
    logic        ack1, busy1, ack2, busy2;
    logic [3:0]  an1, an2;
    logic [7:0]  seg1, seg2;

    obs_t q1[$];
    obs_t q2[$];
    int   tag1[$];
    int   tag2[$];
    int   errors = 0;
    int   checks = 0;
    int   tnum = 0;
    bit   ack_prev = 1'b0;

    seg_display_scheduler #(.DIV(DIV), .BLANK(BLK), .HOLD_FRAMES(2)) u_dut (
        .clk(clk), .rst(rst), .score_pat(score_pat), .msg_req(msg_req), .msg_pat(msg_pat),
        .msg_ack(ack1), .msg_busy(busy1), .digi_an(an1), .digi_seg(seg1)
    );

    seg_display_scheduler #(.DIV(DIV2), .BLANK(0), .HOLD_FRAMES(2)) u_dut2 (
        .clk(clk), .rst(rst), .score_pat(score_pat), .msg_req(msg_req2), .msg_pat(msg_pat),
        .msg_ack(ack2), .msg_busy(busy2), .digi_an(an2), .digi_seg(seg2)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [31:0] pat, int i, int div, int blank,
                                logic busy, logic ack);
        obs_t e;
        int d;
        int s;
        d = i / div;
        s = i % div;
        if (s < blank) begin
            e.an  = 4'hF;
            e.seg = 8'hFF;
        end else begin
            e.an  = ~(4'b1000 >> d);
            e.seg = pat[31-8*d -: 8];
        end
        e.ack  = ack;
        e.busy = busy;
        return e;
    endfunction

    // The requester drops msg_req in the cycle after it sees msg_ack.
    task automatic step1(input obs_t e);
        @(posedge clk);
        q1.push_back(e);
        tag1.push_back(tnum);
        #1;
        if (ack_prev) msg_req = 1'b0;
        ack_prev = ack1;
    endtask

    task automatic step2(input obs_t e);
        @(posedge clk);
        q2.push_back(e);
        tag2.push_back(tnum);
        #1;
    endtask

    task automatic run1(input logic [31:0] pat, input logic busy, input int lo, input int hi,
                        input logic lbusy, input logic lack);
        for (int i = lo; i <= hi; i++)
            step1(mk(pat, i, DIV, BLK, (i == FR-1) ? lbusy : busy, (i == FR-1) ? lack : 1'b0));
    endtask

    task automatic run2(input logic [31:0] pat, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            step2(mk(pat, i, DIV2, 0, 1'b0, 1'b0));
    endtask

    task automatic rst_step(input bit both);
        obs_t r;
        r = '{an: 4'hF, seg: 8'hFF, ack: 1'b0, busy: 1'b0};
        rst = 1'b1;
        @(posedge clk);
        q1.push_back(r);
        tag1.push_back(tnum);
        if (both) begin
            q2.push_back(r);
            tag2.push_back(tnum);
        end
        #1;
        rst = 1'b0;
        ack_prev = ack1;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        int   t;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            t = tag1.pop_front();
            a = {an1, seg1, ack1, busy1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut_div4 test%0d: got an=%b seg=%h ack=%b busy=%b, want an=%b seg=%h ack=%b busy=%b",
                         t, a.an, a.seg, a.ack, a.busy, e.an, e.seg, e.ack, e.busy);
            end
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            t = tag2.pop_front();
            a = {an2, seg2, ack2, busy2};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut_div2 test%0d: got an=%b seg=%h ack=%b busy=%b, want an=%b seg=%h ack=%b busy=%b",
                         t, a.an, a.seg, a.ack, a.busy, e.an, e.seg, e.ack, e.busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state on both instances
        tnum = 0;
        rst_step(1'b1);
        rst_step(1'b1);

        // 1: blank-buffer frame, then the score
        tnum = 1;
        run1(BLANKP, 1'b0, 0, FR-1, 1'b0, 1'b0);
        run1(S,      1'b0, 0, FR-1, 1'b0, 1'b0);

        // 2: message raised mid-frame, shown for two frames, then score returns
        tnum = 2;
        run1(S, 1'b0, 0, 5, 1'b0, 1'b0);
        msg_pat = M;
        msg_req = 1'b1;
        run1(S, 1'b0, 6, FR-1, 1'b1, 1'b1);
        run1(M, 1'b1, 0, FR-1, 1'b1, 1'b0);
        run1(M, 1'b1, 0, FR-1, 1'b0, 1'b0);
        run1(S, 1'b0, 0, FR-1, 1'b0, 1'b0);

        // 3: second request during the message's first frame restarts the hold
        tnum = 3;
        run1(S, 1'b0, 0, 3, 1'b0, 1'b0);
        msg_pat = M;
        msg_req = 1'b1;
        run1(S, 1'b0, 4, FR-1, 1'b1, 1'b1);
        run1(M, 1'b1, 0, 7, 1'b1, 1'b0);
        msg_pat = Z;
        msg_req = 1'b1;
        run1(M, 1'b1, 8, FR-1, 1'b1, 1'b1);
        run1(Z, 1'b1, 0, FR-1, 1'b1, 1'b0);
        run1(Z, 1'b1, 0, FR-1, 1'b0, 1'b0);

        // 4: score change mid-frame lands only at the frame boundary; dropped request ignored
        tnum = 4;
        run1(S, 1'b0, 0, 6, 1'b0, 1'b0);
        score_pat = N;
        run1(S, 1'b0, 7, FR-1, 1'b0, 1'b0);
        run1(N, 1'b0, 0, 3, 1'b0, 1'b0);
        msg_pat = M2;
        msg_req = 1'b1;
        run1(N, 1'b0, 4, 11, 1'b0, 1'b0);
        msg_req = 1'b0;
        run1(N, 1'b0, 12, FR-1, 1'b0, 1'b0);
        run1(N, 1'b0, 0, FR-1, 1'b0, 1'b0);

        // 5: reset while showing a message discards it
        tnum = 5;
        run1(N, 1'b0, 0, 1, 1'b0, 1'b0);
        msg_req = 1'b1;
        run1(N, 1'b0, 2, FR-1, 1'b1, 1'b1);
        run1(M2, 1'b1, 0, 5, 1'b1, 1'b0);
        rst_step(1'b0);
        run1(BLANKP, 1'b0, 0, FR-1, 1'b0, 1'b0);
        run1(N,      1'b0, 0, FR-1, 1'b0, 1'b0);

        // 6: DIV=2, BLANK=0 instance: no off cycles, 8-cycle frames
        tnum = 6;
        rst_step(1'b1);
        run2(BLANKP, 0, FR2-1);
        run2(N, 0, FR2-1);
        run2(N, 0, FR2-1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
